// File: rtl/elastic_pipeline_stage.sv
// One register slice of the elastic pipeline: a valid bit and its payload,
// loaded whenever the parent's advance signal for this slot is high.
module elastic_pipeline_stage #(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  adv,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  v_q;
  logic [DATA_WIDTH-1:0] d_q;

  // NOTE: non-blocking assignments keep every slice sampling its neighbour's
  // pre-edge value, so a full pipe shifts by exactly one slot per edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v_q <= 1'b0;
      // NOTE: the payload is cleared too, so M_DATA reads 0 after reset
      // rather than whatever was last in flight.
      d_q <= '0;
    end else if (adv) begin
      v_q <= in_valid;
      // Bubbles leave the payload untouched to avoid needless toggling.
      if (in_valid) begin
        d_q <= in_data;
      end
    end
  end

  assign out_valid = v_q;
  assign out_data  = d_q;

endmodule

// File: rtl/elastic_pipeline.sv
// Valid/ready pipeline of NUM_STAGES register slices with bubble collapse;
// NUM_STAGES == 0 degenerates to a wire-through.
module elastic_pipeline #(
  parameter int NUM_STAGES = 2,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA
);

  generate
    if (NUM_STAGES < 0) begin : g_illegal
      $error("elastic_pipeline: NUM_STAGES must be >= 0");
    end else if (NUM_STAGES == 0) begin : g_bypass
      assign M_VALID = S_VALID;
      assign M_DATA  = S_DATA;
      assign S_READY = M_READY;
    end else begin : g_pipe
      // Unpacked per-slot signals keep the ripple-back advance chain acyclic
      // at bit level.
      logic                  v   [NUM_STAGES];
      logic [DATA_WIDTH-1:0] d   [NUM_STAGES];
      logic                  adv [NUM_STAGES];

      for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                  in_valid;
        logic [DATA_WIDTH-1:0] in_data;

        if (k == 0) begin : g_head
          assign in_valid = S_VALID;
          assign in_data  = S_DATA;
        end else begin : g_body
          assign in_valid = v[k-1];
          assign in_data  = d[k-1];
        end

        // A slot may load if it is empty or the slot ahead is moving.
        if (k == NUM_STAGES - 1) begin : g_tail_adv
          assign adv[k] = M_READY || !v[k];
        end else begin : g_body_adv
          assign adv[k] = adv[k+1] || !v[k];
        end

        elastic_pipeline_stage #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
          .CLK       (CLK),
          .RESET     (RESET),
          .in_valid  (in_valid),
          .in_data   (in_data),
          .adv       (adv[k]),
          .out_valid (v[k]),
          .out_data  (d[k])
        );
      end

      assign S_READY = adv[0];
      assign M_VALID = v[NUM_STAGES-1];
      assign M_DATA  = d[NUM_STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_elastic_pipeline.sv
// Scoreboard bench for elastic_pipeline: two-, three- and zero-stage instances
// driven with directed vectors, then a long random handshake run.
module tb_elastic_pipeline;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic [DW-1:0] a_s_data, a_m_data;
  logic          b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [DW-1:0] b_s_data, b_m_data;
  logic          z_s_valid, z_s_ready, z_m_valid, z_m_ready;
  logic [DW-1:0] z_s_data, z_m_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  always #5 clk = ~clk;

  elastic_pipeline #(.NUM_STAGES(2), .DATA_WIDTH(DW)) u_dut_a (
    .CLK(clk), .RESET(rst),
    .S_VALID(a_s_valid), .S_READY(a_s_ready), .S_DATA(a_s_data),
    .M_VALID(a_m_valid), .M_READY(a_m_ready), .M_DATA(a_m_data)
  );

  elastic_pipeline #(.NUM_STAGES(3), .DATA_WIDTH(DW)) u_dut_b (
    .CLK(clk), .RESET(rst),
    .S_VALID(b_s_valid), .S_READY(b_s_ready), .S_DATA(b_s_data),
    .M_VALID(b_m_valid), .M_READY(b_m_ready), .M_DATA(b_m_data)
  );

  elastic_pipeline #(.NUM_STAGES(0), .DATA_WIDTH(DW)) u_dut_z (
    .CLK(clk), .RESET(rst),
    .S_VALID(z_s_valid), .S_READY(z_s_ready), .S_DATA(z_s_data),
    .M_VALID(z_m_valid), .M_READY(z_m_ready), .M_DATA(z_m_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  // Inputs are stable by the falling edge, so a handshake seen here is the
  // transfer that the next rising edge will commit.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      qa.delete();
    end else begin
      if (a_m_valid && a_m_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_out: got 0x%0h expected no output", a_m_data);
        end else begin
          e = qa.pop_front();
          check("a_out_data", {24'h0, a_m_data}, {24'h0, e});
        end
      end
      if (a_s_valid && a_s_ready) qa.push_back(a_s_data);
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      qb.delete();
    end else begin
      if (b_m_valid && b_m_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_out: got 0x%0h expected no output", b_m_data);
        end else begin
          e = qb.pop_front();
          check("b_out_data", {24'h0, b_m_data}, {24'h0, e});
        end
      end
      if (b_s_valid && b_s_ready) qb.push_back(b_s_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] t1_data [3];
    logic          mv [8];
    logic [DW-1:0] md [8];
    int            cnt;
    int            first;

    a_s_valid = 0; a_s_data = '0; a_m_ready = 0;
    b_s_valid = 0; b_s_data = '0; b_m_ready = 0;
    z_s_valid = 0; z_s_data = '0; z_m_ready = 0;
    rst = 1;
    cyc();
    cyc();
    rst = 0;

    // Reset state
    mid();
    check("rst_a_m_valid", {31'h0, a_m_valid}, 32'h0);
    check("rst_a_m_data",  {24'h0, a_m_data},  32'h0);
    check("rst_a_s_ready", {31'h0, a_s_ready}, 32'h1);
    check("rst_b_s_ready", {31'h0, b_s_ready}, 32'h1);
    cyc();

    // Streaming: three back-to-back payloads with the sink always ready
    t1_data = '{8'h11, 8'h22, 8'h33};
    a_m_ready = 1;
    cnt = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      a_s_valid = (i < 3);
      if (i < 3) a_s_data = t1_data[i];
      mid();
      mv[i] = a_m_valid;
      md[i] = a_m_data;
      if (a_m_valid) begin
        cnt++;
        if (first < 0) first = i;
      end
      cyc();
    end
    check("t1_valid_cycles", cnt, 3);
    check("t1_first_valid",  first, 2);
    check("t1_data_c2", {24'h0, md[2]}, 32'h11);
    check("t1_data_c3", {24'h0, md[3]}, 32'h22);
    check("t1_data_c4", {24'h0, md[4]}, 32'h33);
    check("t1_idle_c5", {31'h0, mv[5]}, 32'h0);

    // Fill with sink stalled, then release
    a_m_ready = 0;
    a_s_valid = 1; a_s_data = 8'hA1;
    mid(); check("t2_ready_c0", {31'h0, a_s_ready}, 32'h1); cyc();
    a_s_data = 8'hA2;
    mid(); check("t2_ready_c1", {31'h0, a_s_ready}, 32'h1); cyc();
    a_s_data = 8'hA3;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("t2_full_s_ready", {31'h0, a_s_ready}, 32'h0);
      check("t2_hold_m_valid", {31'h0, a_m_valid}, 32'h1);
      check("t2_hold_m_data",  {24'h0, a_m_data},  32'hA1);
      cyc();
    end
    a_m_ready = 1;
    mid();
    check("t2_ready_same_cycle", {31'h0, a_s_ready}, 32'h1);
    check("t2_out_c4", {24'h0, a_m_data}, 32'hA1);
    cyc();
    a_s_valid = 0;
    mid(); check("t2_out_c5", {24'h0, a_m_data}, 32'hA2); cyc();
    mid(); check("t2_out_c6", {24'h0, a_m_data}, 32'hA3); cyc();
    mid(); check("t2_empty_c7", {31'h0, a_m_valid}, 32'h0); cyc();

    // Reset mid-stream with a coincident push that must be dropped
    a_m_ready = 0;
    a_s_valid = 1; a_s_data = 8'hB1; cyc();
    a_s_data = 8'hB2; cyc();
    a_s_data = 8'hCC; rst = 1;
    mid(); cyc();
    rst = 0; a_s_valid = 0;
    mid();
    check("t4_m_valid", {31'h0, a_m_valid}, 32'h0);
    check("t4_m_data",  {24'h0, a_m_data},  32'h0);
    check("t4_s_ready", {31'h0, a_s_ready}, 32'h1);
    cyc();
    a_m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t4_no_old_data", {31'h0, a_m_valid}, 32'h0);
      cyc();
    end

    // Bubble collapse on the three-stage instance
    b_s_valid = 1; b_s_data = 8'h5C;
    mid(); check("t3_ready_c0", {31'h0, b_s_ready}, 32'h1); cyc();
    b_s_valid = 0;
    for (int i = 1; i < 3; i++) begin
      mid();
      check("t3_not_yet_valid", {31'h0, b_m_valid}, 32'h0);
      check("t3_ready_bubble",  {31'h0, b_s_ready}, 32'h1);
      cyc();
    end
    b_s_valid = 1; b_s_data = 8'h5D;
    mid();
    check("t3_arrive_valid", {31'h0, b_m_valid}, 32'h1);
    check("t3_arrive_data",  {24'h0, b_m_data},  32'h5C);
    check("t3_ready_c3",     {31'h0, b_s_ready}, 32'h1);
    cyc();
    b_s_data = 8'h5E;
    mid(); check("t3_ready_c4", {31'h0, b_s_ready}, 32'h1); cyc();
    b_s_data = 8'h5F;
    mid(); check("t3_full_s_ready", {31'h0, b_s_ready}, 32'h0); cyc();
    b_m_ready = 1;
    mid(); check("t3_ready_release", {31'h0, b_s_ready}, 32'h1); cyc();
    b_s_valid = 0;
    repeat (6) cyc();

    // Zero-stage pass-through
    z_s_valid = 1; z_s_data = 8'h7E; z_m_ready = 0;
    mid();
    check("t5_m_valid", {31'h0, z_m_valid}, 32'h1);
    check("t5_m_data",  {24'h0, z_m_data},  32'h7E);
    check("t5_s_ready", {31'h0, z_s_ready}, 32'h0);
    cyc();
    z_m_ready = 1;
    mid(); check("t5_s_ready_hi", {31'h0, z_s_ready}, 32'h1); cyc();

    // Random handshakes on both sides
    for (int i = 0; i < 10000; i++) begin
      a_s_valid = 1'($urandom_range(0, 1));
      a_s_data  = 8'($urandom);
      a_m_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    a_s_valid = 0;
    a_m_ready = 1;
    repeat (5) cyc();
    mid();
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
